// File: rtl/output_port_allocator.sv
// Per-output-port wormhole switch allocator: round-robin arbitration among input heads,
// locks the output to the winner until TAIL (or watchdog), and muxes/pops under valid/ready.
module output_port_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 19,
    parameter int MAX_FLITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS*FLIT_W-1:0] flit_i,
    input  logic [NUM_PORTS-1:0]        flit_valid_i,
    input  logic                        ds_ready_i,
    output logic [FLIT_W-1:0]           flit_o,
    output logic                        flit_valid_o,
    output logic [NUM_PORTS-1:0]        pop_o,
    output logic [NUM_PORTS-1:0]        grant_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(MAX_FLITS + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [1:0] TYPE_HEAD = 2'd0;
    localparam logic [1:0] TYPE_TAIL = 2'd1;
    localparam logic [1:0] TYPE_NONE = 2'd3;

    logic [0:0]        state;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_found;
    logic [CNT_W-1:0]  flit_cnt;
    logic [FLIT_W-1:0] cur_flit;
    logic [1:0]        cur_type;
    logic              cur_valid;
    logic              active;
    logic              xfer;
    logic              last_flit_slot;
    logic              last_xfer;
    logic              violation;

    // Scanning offsets from high to low leaves the lowest offset from rr_ptr as the winner.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_i[(int'(rr_ptr) + k) % NUM_PORTS]) begin
                arb_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
                arb_found = 1'b1;
            end
        end
    end

    assign active         = (state == ACTIVE);
    assign cur_flit       = flit_i[int'(owner)*FLIT_W +: FLIT_W];
    assign cur_type       = cur_flit[FLIT_W-2 -: 2];
    assign cur_valid      = flit_valid_i[owner];
    assign xfer           = active && cur_valid && ds_ready_i;
    assign last_flit_slot = (flit_cnt == CNT_W'(MAX_FLITS - 1));
    assign last_xfer      = xfer && ((cur_type == TYPE_TAIL) || last_flit_slot);

    // A TAIL landing exactly on the watchdog slot is a clean release, not a violation.
    assign violation = xfer && (((flit_cnt == '0) && (cur_type != TYPE_HEAD)) ||
                                ((flit_cnt != '0) && (cur_type == TYPE_HEAD)) ||
                                (cur_type == TYPE_NONE) ||
                                (last_flit_slot && (cur_type != TYPE_TAIL)));

    assign flit_o       = active ? cur_flit : '0;
    assign flit_valid_o = active && cur_valid && (cur_type != TYPE_NONE);
    assign pop_o        = xfer ? (NUM_PORTS'(1) << owner) : '0;
    assign grant_o      = active ? (NUM_PORTS'(1) << owner) : '0;
    assign busy_o       = active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            flit_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= violation;
            if (state == IDLE) begin
                if (arb_found) begin
                    state    <= ACTIVE;
                    owner    <= arb_idx;
                    flit_cnt <= '0;
                end
            end else begin
                if (last_xfer) begin
                    state    <= IDLE;
                    flit_cnt <= '0;
                    rr_ptr   <= (owner == PTR_W'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
                end else if (xfer) begin
                    flit_cnt <= flit_cnt + 1'b1;
                end
            end
        end
    end

endmodule
